result_checker: RTL and testbench

Synthesizable self-checking unit that compares a DUT result memory against a golden memory after a compute run. It replaces bench-side sweep loops with a cycle-accurate scanner. It sits beside the top controller and reads both memories through one shared read port. It reports mismatch count, the first failing address and its data, and pass/fail. It is generalised in word width, depth, lanes compared per cycle, memory read latency and scan mode (full scan or stop-on-first-error).

---
 rtl/result_checker_if.sv | 13 +
 rtl/result_checker.sv | 162 ++++++++++++++++
 tb/tb_result_checker.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/result_checker_if.sv
// result_checker_if: shared read port from the checker to the DUT and golden memories
interface result_checker_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 22,
   parameter int LANES  = 1
);
   logic                    rd_en;
   logic [ADDR_W-1:0]       rd_addr;
   logic [LANES*DATA_W-1:0] dut_rd_data;
   logic [LANES*DATA_W-1:0] ref_rd_data;
   modport master (output rd_en, rd_addr, input dut_rd_data, ref_rd_data);
   modport slave (input rd_en, rd_addr, output dut_rd_data, ref_rd_data);
endinterface

// File: rtl/result_checker.sv
// result_checker: scans DUT vs golden memory, reports mismatch count, first failing word and pass/fail
module result_checker #(
   parameter int DATA_W = 22,
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = 12,
   parameter int LANES  = 1,
   parameter int RD_LAT = 1,
   parameter int ERR_W  = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
   input  logic               stop_on_err,
   result_checker_if.master   mem,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [ERR_W-1:0]   err_cnt,
   output logic               first_err_valid,
   output logic [ADDR_W-1:0]  first_err_addr,
   output logic [DATA_W-1:0]  first_err_dut,
   output logic [DATA_W-1:0]  first_err_ref
);
   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - LANES);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(LANES);
   state_t                        state_q, state_d;
   logic                          rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic                          first_err_valid_q, first_err_valid_d, stop_q, stop_d, halt_q, halt_d;
   logic [ADDR_W-1:0]             rd_addr_q, rd_addr_d, first_err_addr_q, first_err_addr_d, lane;
   logic [ERR_W-1:0]              err_cnt_q, err_cnt_d;
   logic [DATA_W-1:0]             first_err_dut_q, first_err_dut_d, first_err_ref_q, first_err_ref_d;
   logic [DATA_W-1:0]             lane_dut, lane_ref;
   logic [RD_LAT-1:0]             pv_q, pv_d;
   logic [RD_LAT-1:0][ADDR_W-1:0] pa_q, pa_d;
   logic [LANES-1:0]              mm;
   logic [ERR_W:0]                n, sum;
   logic                          hit;
   assign mem.rd_en       = rd_en_q;
   assign mem.rd_addr     = rd_addr_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign err_cnt         = err_cnt_q;
   assign first_err_valid = first_err_valid_q;
   assign first_err_addr  = first_err_addr_q;
   assign first_err_dut   = first_err_dut_q;
   assign first_err_ref   = first_err_ref_q;
   always_comb begin
      mm       = '0;
      n        = '0;
      lane     = '0;
      lane_dut = '0;
      lane_ref = '0;
      // descending walk so the lowest mismatching lane is the one left captured
      for (int i = LANES - 1; i >= 0; i--) begin
         mm[i] = mem.dut_rd_data[i*DATA_W +: DATA_W] != mem.ref_rd_data[i*DATA_W +: DATA_W];
         n     = n + (ERR_W+1)'(mm[i]);
         if (mm[i]) begin
            lane     = ADDR_W'(i);
            lane_dut = mem.dut_rd_data[i*DATA_W +: DATA_W];
            lane_ref = mem.ref_rd_data[i*DATA_W +: DATA_W];
         end
      end
      // halt_q discards beats still in flight after a stop-mode mismatch
      hit               = pv_q[RD_LAT-1] && !halt_q && |mm;
      sum               = {1'b0, err_cnt_q} + n;
      state_d           = state_q;
      rd_en_d           = rd_en_q;
      rd_addr_d         = rd_addr_q;
      busy_d            = busy_q;
      done_d            = 1'b0;
      pass_d            = pass_q;
      err_cnt_d         = err_cnt_q;
      first_err_valid_d = first_err_valid_q;
      first_err_addr_d  = first_err_addr_q;
      first_err_dut_d   = first_err_dut_q;
      first_err_ref_d   = first_err_ref_q;
      stop_d            = stop_q;
      halt_d            = halt_q;
      pv_d[0]           = rd_en_q;
      pa_d[0]           = rd_addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
         pv_d[i] = pv_q[i-1];
         pa_d[i] = pa_q[i-1];
      end
      if (hit) begin
         err_cnt_d = sum[ERR_W] ? '1 : sum[ERR_W-1:0];
         halt_d    = stop_q;
         if (!first_err_valid_q) begin
            first_err_valid_d = 1'b1;
            first_err_addr_d  = pa_q[RD_LAT-1] + lane;
            first_err_dut_d   = lane_dut;
            first_err_ref_d   = lane_ref;
         end
      end
      case (state_q)
         IDLE: if (start) begin
            state_d           = READ;
            rd_en_d           = 1'b1;
            rd_addr_d         = '0;
            busy_d            = 1'b1;
            pass_d            = 1'b0;
            err_cnt_d         = '0;
            first_err_valid_d = 1'b0;
            first_err_addr_d  = '0;
            first_err_dut_d   = '0;
            first_err_ref_d   = '0;
            stop_d            = stop_on_err;
            halt_d            = 1'b0;
         end
         READ: if ((hit && stop_q) || rd_addr_q == LAST) begin
            state_d = DRAIN;
            rd_en_d = 1'b0;
         end else rd_addr_d = rd_addr_q + STEP;
         DRAIN: if (!(|pv_q)) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = err_cnt_q == '0;
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q           <= IDLE;
         rd_en_q           <= 1'b0;
         rd_addr_q         <= '0;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         pass_q            <= 1'b0;
         err_cnt_q         <= '0;
         first_err_valid_q <= 1'b0;
         first_err_addr_q  <= '0;
         first_err_dut_q   <= '0;
         first_err_ref_q   <= '0;
         stop_q            <= 1'b0;
         halt_q            <= 1'b0;
         pv_q              <= '0;
         pa_q              <= '0;
      end else begin
         state_q           <= state_d;
         rd_en_q           <= rd_en_d;
         rd_addr_q         <= rd_addr_d;
         busy_q            <= busy_d;
         done_q            <= done_d;
         pass_q            <= pass_d;
         err_cnt_q         <= err_cnt_d;
         first_err_valid_q <= first_err_valid_d;
         first_err_addr_q  <= first_err_addr_d;
         first_err_dut_q   <= first_err_dut_d;
         first_err_ref_q   <= first_err_ref_d;
         stop_q            <= stop_d;
         halt_q            <= halt_d;
         pv_q              <= pv_d;
         pa_q              <= pa_d;
      end
   end
endmodule

// File: tb/tb_result_checker.sv
// tb_result_checker: runs two checker configurations against memory models and a scan-level reference
module tb_result_checker;
   localparam int DW = 22, DEPTH = 4096, AW = 12;
   logic clk = 1'b0, rstn = 1'b0, start0 = 1'b0, start1 = 1'b0, soe = 1'b0, sel = 1'b0;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   result_checker_if #(.ADDR_W(AW), .DATA_W(DW), .LANES(1)) m0 ();
   result_checker_if #(.ADDR_W(AW), .DATA_W(DW), .LANES(4)) m1 ();
   logic busy0, done0, pass0, fev0, busy1, done1, pass1, fev1;
   logic [15:0] ec0;
   logic [3:0] ec1;
   logic [AW-1:0] fea0, fea1;
   logic [DW-1:0] fed0, fer0, fed1, fer1;
   result_checker #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .LANES(1), .RD_LAT(1), .ERR_W(16)) u0 (
      .clk(clk), .rstn(rstn), .start(start0), .stop_on_err(soe), .mem(m0), .busy(busy0), .done(done0),
      .pass(pass0), .err_cnt(ec0), .first_err_valid(fev0), .first_err_addr(fea0),
      .first_err_dut(fed0), .first_err_ref(fer0));
   result_checker #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .LANES(4), .RD_LAT(3), .ERR_W(4)) u1 (
      .clk(clk), .rstn(rstn), .start(start1), .stop_on_err(soe), .mem(m1), .busy(busy1), .done(done1),
      .pass(pass1), .err_cnt(ec1), .first_err_valid(fev1), .first_err_addr(fea1),
      .first_err_dut(fed1), .first_err_ref(fer1));
   logic [DW-1:0] md [DEPTH];
   logic [DW-1:0] mr [DEPTH];
   logic [DW-1:0] d0, r0;
   logic [2:0][4*DW-1:0] d1, r1;
   assign m0.dut_rd_data = d0;
   assign m0.ref_rd_data = r0;
   assign m1.dut_rd_data = d1[2];
   assign m1.ref_rd_data = r1[2];
   always @(posedge clk) if (m0.rd_en) begin
      d0 <= md[m0.rd_addr];
      r0 <= mr[m0.rd_addr];
   end
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         d1[0][i*DW +: DW] <= md[m1.rd_addr + AW'(i)];
         r1[0][i*DW +: DW] <= mr[m1.rd_addr + AW'(i)];
      end
      d1[2:1] <= d1[1:0];
      r1[2:1] <= r1[1:0];
   end
   logic busy_s, done_s, pass_s, fev_s, rd_en_s;
   logic [15:0] ec_s;
   logic [AW-1:0] fea_s, rd_addr_s;
   logic [DW-1:0] fed_s, fer_s;
   assign busy_s    = sel ? busy1 : busy0;
   assign done_s    = sel ? done1 : done0;
   assign pass_s    = sel ? pass1 : pass0;
   assign fev_s     = sel ? fev1 : fev0;
   assign rd_en_s   = sel ? m1.rd_en : m0.rd_en;
   assign ec_s      = sel ? {12'b0, ec1} : ec0;
   assign fea_s     = sel ? fea1 : fea0;
   assign rd_addr_s = sel ? m1.rd_addr : m0.rd_addr;
   assign fed_s     = sel ? fed1 : fed0;
   assign fer_s     = sel ? fer1 : fer0;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, ".busy"}, busy_s, 0);
      chk({tag, ".done"}, done_s, 0);
      chk({tag, ".pass"}, pass_s, 0);
      chk({tag, ".err"}, ec_s, 0);
      chk({tag, ".fev"}, fev_s, 0);
      chk({tag, ".fea"}, fea_s, 0);
      chk({tag, ".fed"}, fed_s, 0);
      chk({tag, ".fer"}, fer_s, 0);
      chk({tag, ".rd_en"}, rd_en_s, 0);
      chk({tag, ".rd_addr"}, rd_addr_s, 0);
   endtask
   task automatic fill();
      for (int a = 0; a < DEPTH; a++) begin
         mr[a] = DW'($urandom);
         md[a] = mr[a];
      end
   endtask
   task automatic flip(input int a);
      md[a] = md[a] ^ DW'($urandom_range(1, 22'h3FFFFF));
   endtask
   // scan-level expectation: which words differ, and how the beat/latency rules place done
   task automatic model(input int l, input int lat, input int ew, input bit stop,
                        output int err, output int first, output int done_e, output int beats);
      int nb, cnt, b, m, lim, mx;
      nb = DEPTH / l;
      cnt = 0;
      first = -1;
      mx = (1 << ew) - 1;
      for (int a = 0; a < DEPTH; a++) if (md[a] != mr[a]) begin
         if (first < 0) first = a;
         cnt++;
      end
      lim = nb;
      if (first >= 0 && stop) begin
         b = first / l;
         cnt = 0;
         for (int a = b * l; a < b * l + l; a++) if (md[a] != mr[a]) cnt++;
         m = b + 1 + lat;
         lim = m < nb ? m : nb;
      end
      err = cnt > mx ? mx : cnt;
      beats = lim;
      done_e = lim + lat + 1;
   endtask
   task automatic run(input bit stop, input bit extra, output int e, output int beats);
      e = -1;
      beats = 0;
      @(negedge clk);
      soe = stop;
      if (sel) start1 = 1'b1; else start0 = 1'b1;
      for (int k = 0; k < 6000; k++) begin
         @(posedge clk);
         @(negedge clk);
         start0 = 1'b0;
         start1 = 1'b0;
         soe = ~stop;
         if (extra && k == 50) begin
            if (sel) start1 = 1'b1; else start0 = 1'b1;
         end
         if (rd_en_s) beats++;
         if (done_s) begin
            e = k;
            break;
         end
      end
      start0 = 1'b0;
      start1 = 1'b0;
      chk("done_seen", done_s, 1);
   endtask
   task automatic check_run(input string tag, input bit stop, input bit extra);
      int err, first, de, bt, e, beats;
      model(sel ? 4 : 1, sel ? 3 : 1, sel ? 4 : 16, stop, err, first, de, bt);
      run(stop, extra, e, beats);
      chk({tag, ".done_edge"}, e, de);
      chk({tag, ".beats"}, beats, bt);
      chk({tag, ".busy_at_done"}, busy_s, 1);
      chk({tag, ".err"}, ec_s, err);
      chk({tag, ".pass"}, pass_s, err == 0);
      chk({tag, ".fev"}, fev_s, first >= 0);
      chk({tag, ".fea"}, fea_s, first >= 0 ? first : 0);
      chk({tag, ".fed"}, fed_s, first >= 0 ? md[first] : 0);
      chk({tag, ".fer"}, fer_s, first >= 0 ? mr[first] : 0);
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".done_pulse"}, done_s, 0);
      chk({tag, ".busy_after"}, busy_s, 0);
      chk({tag, ".err_hold"}, ec_s, err);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      sel = 1'b0;
      #1 chk_zero("por0");
      sel = 1'b1;
      #1 chk_zero("por1");
      rstn = 1'b1;
      sel = 1'b0;
      fill();
      check_run("equal", 1'b0, 1'b1);
      mr[5] = 22'h000001;
      md[5] = 22'h3FFFFF;
      flip(100);
      flip(4095);
      check_run("three", 1'b0, 1'b0);
      sel = 1'b1;
      check_run("stop_l4", 1'b1, 1'b0);
      check_run("full_l4", 1'b0, 1'b1);
      fill();
      flip(9);
      flip(11);
      check_run("lanes13", 1'b0, 1'b0);
      for (int a = 0; a < DEPTH; a++) flip(a);
      check_run("sat", 1'b0, 1'b0);
      check_run("sat_stop", 1'b1, 1'b0);
      sel = 1'b0;
      fill();
      flip(77);
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (2000) @(negedge clk);
      chk("rst.pre_busy", busy_s, 1);
      chk("rst.pre_err", ec_s, 1);
      rstn = 1'b0;
      #1 chk_zero("rst");
      @(negedge clk);
      rstn = 1'b1;
      check_run("after_rst", 1'b0, 1'b0);
      for (int r = 0; r < 8; r++) begin
         sel = r[0];
         fill();
         for (int j = $urandom_range(0, 5); j > 0; j--) flip($urandom_range(0, DEPTH - 1));
         check_run($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'b0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
